// File: rtl/mem_unit_pkg.sv
// Shared encodings for the memory stage: bus/memory mode codes and FSM states.
// Imported by the memory unit and by anything that drives its control inputs.
package mem_unit_pkg;

    localparam int WORD = 16;

    localparam logic [1:0] MAR_BUS_R    = 2'b01;
    localparam logic [1:0] MAR_BUS_W    = 2'b10;
    localparam logic [1:0] MDR_BUS_R    = 2'b01;
    localparam logic [1:0] MDR_BUS_W    = 2'b10;
    localparam logic [1:0] MDR_MEM_R    = 2'b01;
    localparam logic [1:0] MDR_MEM_W    = 2'b10;
    localparam logic [1:0] MEM_MODE_OUT = 2'b01;
    localparam logic [1:0] MEM_MODE_IN  = 2'b10;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

    function automatic logic is_mem_request(input logic [1:0] mem_mode);
        return (mem_mode == MEM_MODE_OUT) || (mem_mode == MEM_MODE_IN);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, registered read.
module mem_array #(
    parameter int    WORD_W    = 16,
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // NOTE: the array has no reset; clearing it would turn a block RAM into
    // thousands of flops, and software never relies on power-up contents.
    logic [WORD_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_unit.sv
// Memory-side datapath stage: MAR/MDR registers, bus drive mux, and a timed
// request FSM that reads/writes a word-addressed RAM on behalf of control.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int    WORD_W    = WORD,
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] bus_in,
    output logic [WORD_W-1:0] bus_out,
    output logic              bus_drive,
    input  logic [1:0]        MARBusMode,
    input  logic [1:0]        MDRBusMode,
    input  logic [1:0]        MDRMemMode,
    input  logic [1:0]        MemMode,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic [WORD_W-1:0] mar_q,
    output logic [WORD_W-1:0] mdr_q
);

    localparam int CNT_W = 4;

    mem_state_t        state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              is_write_q;

    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_rdata;
    logic              ram_we;
    logic              complete;
    logic              mar_load;
    logic              mdr_load;
    logic              req_valid;
    logic              proto_err;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the ifs can leave a latch behind.
    always_comb begin
        bus_out   = '0;
        bus_drive = 1'b0;
        if (MDRBusMode == MDR_BUS_W) begin
            bus_out   = mdr_q;
            bus_drive = 1'b1;
        end else if (MARBusMode == MAR_BUS_W) begin
            bus_out   = mar_q;
            bus_drive = 1'b1;
        end
    end

    assign mem_busy  = (state == MEM_WAIT);
    assign complete  = mem_busy && (count == '0);
    assign mar_load  = (MARBusMode == MAR_BUS_R);
    assign mdr_load  = (MDRBusMode == MDR_BUS_R);
    assign req_valid = ((MemMode == MEM_MODE_OUT) && (MDRMemMode == MDR_MEM_R)) ||
                       ((MemMode == MEM_MODE_IN)  && (MDRMemMode == MDR_MEM_W));

    assign proto_err = ((MDRBusMode == MDR_BUS_W) && (MARBusMode == MAR_BUS_W)) ||
                       ((mar_load || mdr_load) && bus_drive) ||
                       (is_mem_request(MemMode) && (mem_busy || !req_valid)) ||
                       (mdr_load && mem_busy);

    // RAM sees the live MAR while idle so a read is already in flight by the
    // first WAIT edge; once busy the latched address protects the access.
    assign ram_addr = mem_busy ? addr_q : mar_q[ADDR_W-1:0];
    assign ram_we   = complete && is_write_q && !reset;

    mem_array #(
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, which is what lets a request use the old MAR/MDR
    // while the same edge loads new ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MEM_IDLE;
            count      <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            mem_done   <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            mem_done <= complete;
            if (proto_err) begin
                mem_err <= 1'b1;
            end
            if (mar_load) begin
                mar_q <= bus_in;
            end
            case (state)
                MEM_IDLE: begin
                    if (mdr_load) begin
                        mdr_q <= bus_in;
                    end
                    if (req_valid) begin
                        addr_q     <= mar_q[ADDR_W-1:0];
                        wdata_q    <= mdr_q;
                        is_write_q <= (MemMode == MEM_MODE_IN);
                        count      <= CNT_W'(LATENCY - 1);
                        state      <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        if (!is_write_q) begin
                            mdr_q <= ram_rdata;
                        end
                        state <= MEM_IDLE;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model; LATENCY 1 and 15 copies for timing.
module tb_mem_unit;
    import mem_unit_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bus_in = '0;
    logic [1:0]  mar_mode = '0, mdr_mode = '0, mdr_mem_mode = '0, mem_mode = '0;

    logic [15:0] dut_bus_out, dut_mar, dut_mdr;
    logic        dut_drive, dut_busy, dut_done, dut_err;
    logic [15:0] l1_bus_out, l1_mar, l1_mdr;
    logic        l1_drive, l1_busy, l1_done, l1_err;
    logic [15:0] l15_bus_out, l15_mar, l15_mdr;
    logic        l15_drive, l15_busy, l15_done, l15_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    mem_unit #(.WORD_W(16), .ADDR_W(10), .LATENCY(LAT), .INIT_FILE("")) u_dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(dut_bus_out), .bus_drive(dut_drive),
        .MARBusMode(mar_mode), .MDRBusMode(mdr_mode), .MDRMemMode(mdr_mem_mode), .MemMode(mem_mode),
        .mem_busy(dut_busy), .mem_done(dut_done), .mem_err(dut_err), .mar_q(dut_mar), .mdr_q(dut_mdr));

    mem_unit #(.WORD_W(16), .ADDR_W(10), .LATENCY(1), .INIT_FILE("")) u_lat1 (
        .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(l1_bus_out), .bus_drive(l1_drive),
        .MARBusMode(mar_mode), .MDRBusMode(mdr_mode), .MDRMemMode(mdr_mem_mode), .MemMode(mem_mode),
        .mem_busy(l1_busy), .mem_done(l1_done), .mem_err(l1_err), .mar_q(l1_mar), .mdr_q(l1_mdr));

    mem_unit #(.WORD_W(16), .ADDR_W(10), .LATENCY(15), .INIT_FILE("")) u_lat15 (
        .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(l15_bus_out), .bus_drive(l15_drive),
        .MARBusMode(mar_mode), .MDRBusMode(mdr_mode), .MDRMemMode(mdr_mem_mode), .MemMode(mem_mode),
        .mem_busy(l15_busy), .mem_done(l15_done), .mem_err(l15_err), .mar_q(l15_mar), .mdr_q(l15_mdr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [15:0] m_mar, m_mdr, m_wdata;
    bit          m_mdr_known, m_wdata_known, m_pending, m_is_write, m_done, m_err;
    int          m_addr, m_done_edge, m_edge = 0;
    logic [15:0] m_ram [DEPTH];
    bit          m_ram_known [DEPTH];

    always @(posedge clk) begin : model
        logic [15:0] old_mar, old_mdr;
        bit old_known, mar_r, mdr_r, mar_w, mdr_w, act, valid, finish_now;
        m_edge++;
        if (reset) begin
            m_mar = '0; m_mdr = '0; m_mdr_known = 1;
            m_pending = 0; m_done = 0; m_err = 0;
        end else begin
            old_mar = m_mar; old_mdr = m_mdr; old_known = m_mdr_known;
            mar_r = (mar_mode == MAR_BUS_R);
            mdr_r = (mdr_mode == MDR_BUS_R);
            mar_w = (mar_mode == MAR_BUS_W);
            mdr_w = (mdr_mode == MDR_BUS_W);
            act   = (mem_mode == MEM_MODE_OUT) || (mem_mode == MEM_MODE_IN);
            valid = ((mem_mode == MEM_MODE_OUT) && (mdr_mem_mode == MDR_MEM_R)) ||
                    ((mem_mode == MEM_MODE_IN) && (mdr_mem_mode == MDR_MEM_W));
            if ((mar_w && mdr_w) || ((mar_r || mdr_r) && (mar_w || mdr_w)) ||
                (act && (m_pending || !valid)) || (mdr_r && m_pending))
                m_err = 1;
            finish_now = m_pending && (m_edge == m_done_edge);
            if (mar_r) m_mar = bus_in;
            if (m_pending) begin
                if (finish_now) begin
                    if (m_is_write) begin
                        m_ram[m_addr] = m_wdata;
                        m_ram_known[m_addr] = m_wdata_known;
                    end else begin
                        m_mdr = m_ram[m_addr];
                        m_mdr_known = m_ram_known[m_addr];
                    end
                    m_pending = 0;
                end
            end else begin
                if (mdr_r) begin
                    m_mdr = bus_in;
                    m_mdr_known = 1;
                end
                if (valid) begin
                    m_pending     = 1;
                    m_addr        = int'(old_mar) % DEPTH;
                    m_wdata       = old_mdr;
                    m_wdata_known = old_known;
                    m_is_write    = (mem_mode == MEM_MODE_IN);
                    m_done_edge   = m_edge + LAT;
                end
            end
            m_done = finish_now;
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] exp_out;
        bit exp_drive, out_known;
        if (chk_en) begin
            exp_out = '0; exp_drive = 0; out_known = 1;
            if (mdr_mode == MDR_BUS_W) begin
                exp_out = m_mdr; exp_drive = 1; out_known = m_mdr_known;
            end else if (mar_mode == MAR_BUS_W) begin
                exp_out = m_mar; exp_drive = 1;
            end
            check("model_bus_drive", dut_drive, exp_drive);
            if (out_known) check("model_bus_out", dut_bus_out, exp_out);
            check("model_busy", dut_busy, m_pending);
            check("model_done", dut_done, m_done);
            check("model_err", dut_err, m_err);
            check("model_mar", dut_mar, m_mar);
            if (m_mdr_known) check("model_mdr", dut_mdr, m_mdr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        mar_mode = '0; mdr_mode = '0; mdr_mem_mode = '0; mem_mode = '0; bus_in = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; cyc(); reset = 1'b0;
    endtask

    task automatic load_mar(input logic [15:0] v);
        idle(); mar_mode = MAR_BUS_R; bus_in = v; cyc(); idle();
    endtask

    task automatic load_mdr(input logic [15:0] v);
        idle(); mdr_mode = MDR_BUS_R; bus_in = v; cyc(); idle();
    endtask

    task automatic issue(input bit wr);
        idle();
        mem_mode     = wr ? MEM_MODE_IN : MEM_MODE_OUT;
        mdr_mem_mode = wr ? MDR_MEM_W : MDR_MEM_R;
        cyc(); idle();
    endtask

    // Idle 40 cycles, recording the first cycle after accept that shows done.
    task automatic measure(output int k2, output int k1, output int k15);
        k2 = -1; k1 = -1; k15 = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (dut_done && k2 < 0) k2 = i;
            if (l1_done && k1 < 0) k1 = i;
            if (l15_done && k15 < 0) k15 = i;
        end
    endtask

    task automatic access(input bit wr);
        int k2, k1, k15;
        issue(wr);
        measure(k2, k1, k15);
        check("access_done_cycle", k2, LAT);
    endtask

    function automatic logic [9:0] pick_idx();
        int r = $urandom_range(0, 16);
        return (r == 16) ? 10'h3FF : 10'(r);
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k2, k1, k15, op;
        idle();
        reset = 1'b1;
        cyc();
        chk_en = 1;
        reset = 1'b0;

        // Reset values
        check("rst_mar", dut_mar, 16'h0);
        check("rst_mdr", dut_mdr, 16'h0);
        check("rst_busy", dut_busy, 1'b0);
        check("rst_done", dut_done, 1'b0);
        check("rst_err", dut_err, 1'b0);
        check("rst_drive", dut_drive, 1'b0);

        // Bus drive and dual-drive collision
        load_mdr(16'h00FF);
        mdr_mode = MDR_BUS_W; #1;
        check("drive_mdr_out", dut_bus_out, 16'h00FF);
        check("drive_mdr_en", dut_drive, 1'b1);
        cyc(); idle();
        check("drive_mdr_noerr", dut_err, 1'b0);
        load_mar(16'h0123);
        mar_mode = MAR_BUS_W; #1;
        check("drive_mar_out", dut_bus_out, 16'h0123);
        mdr_mode = MDR_BUS_W; #1;
        check("drive_both_out", dut_bus_out, 16'h00FF);
        cyc(); idle();
        check("drive_both_err", dut_err, 1'b1);

        // Read of 0xBEEF at word 5 with busy/done timing
        do_reset();
        load_mar(16'h0005); load_mdr(16'hBEEF); access(1);
        load_mdr(16'h0000);
        issue(0);
        check("rd_busy1", dut_busy, 1'b1);
        check("rd_done1", dut_done, 1'b0);
        cyc();
        check("rd_busy2", dut_busy, 1'b1);
        cyc();
        check("rd_busy3", dut_busy, 1'b0);
        check("rd_done3", dut_done, 1'b1);
        check("rd_mdr", dut_mdr, 16'hBEEF);
        cyc();
        check("rd_done_pulse", dut_done, 1'b0);
        measure(k2, k1, k15);

        // Write 0x1234 to 0x0A, read back
        load_mar(16'h000A); load_mdr(16'h1234); access(1);
        load_mdr(16'h0000); access(0);
        check("wr_readback", dut_mdr, 16'h1234);

        // Collisions while busy
        do_reset();
        load_mar(16'h0007); load_mdr(16'hA5A5);
        issue(1);
        mem_mode = MEM_MODE_OUT; mdr_mem_mode = MDR_MEM_R;
        mdr_mode = MDR_BUS_R; mar_mode = MAR_BUS_R; bus_in = 16'hDEAD;
        cyc(); idle();
        check("coll_busy", dut_busy, 1'b1);
        check("coll_err", dut_err, 1'b1);
        cyc();
        check("coll_done", dut_done, 1'b1);
        check("coll_mdr_kept", dut_mdr, 16'hA5A5);
        check("coll_mar_loaded", dut_mar, 16'hDEAD);
        measure(k2, k1, k15);
        load_mar(16'h0007); load_mdr(16'h0000); access(0);
        check("coll_write_intact", dut_mdr, 16'hA5A5);

        // Reset in the middle of a write
        do_reset();
        load_mar(16'h0003); load_mdr(16'h7777); access(1);
        load_mdr(16'h1111);
        issue(1);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("mid_rst_mar", dut_mar, 16'h0);
        check("mid_rst_mdr", dut_mdr, 16'h0);
        check("mid_rst_busy", dut_busy, 1'b0);
        check("mid_rst_done", dut_done, 1'b0);
        check("mid_rst_err", dut_err, 1'b0);
        check("mid_rst_drive", dut_drive, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("mid_rst_no_done", dut_done, 1'b0);
        end
        load_mar(16'h0003); access(0);
        check("mid_rst_ram_kept", dut_mdr, 16'h7777);

        // Address wrap at the top word
        do_reset();
        load_mar(16'hFFFF); load_mdr(16'hC0DE); access(1);
        load_mar(16'h03FF); load_mdr(16'h0000); access(0);
        check("wrap_top", dut_mdr, 16'hC0DE);

        // Latency sweep with wrap: 0xFC05 hits word 5
        do_reset();
        load_mar(16'hFC05); load_mdr(16'h5A5A);
        issue(1); measure(k2, k1, k15);
        check("sweep_wr_lat2", k2, 2);
        check("sweep_wr_lat1", k1, 1);
        check("sweep_wr_lat15", k15, 15);
        load_mar(16'h0005); load_mdr(16'h0000);
        issue(0); measure(k2, k1, k15);
        check("sweep_rd_lat2", k2, 2);
        check("sweep_rd_lat1", k1, 1);
        check("sweep_rd_lat15", k15, 15);
        check("sweep_mdr_lat2", dut_mdr, 16'h5A5A);
        check("sweep_mdr_lat1", l1_mdr, 16'h5A5A);
        check("sweep_mdr_lat15", l15_mdr, 16'h5A5A);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            load_mar(16'((i == 16) ? 10'h3FF : 10'(i)));
            load_mdr(16'($urandom));
            issue(1);
            cyc(); cyc(); cyc();
        end
        for (int i = 0; i < 4000; i++) begin
            idle();
            reset  = ($urandom_range(0, 59) == 0);
            bus_in = 16'($urandom);
            op     = $urandom_range(0, 11);
            case (op)
                1: begin mar_mode = MAR_BUS_R; bus_in = {6'($urandom), pick_idx()}; end
                2: mdr_mode = MDR_BUS_R;
                3: mdr_mode = MDR_BUS_W;
                4: mar_mode = MAR_BUS_W;
                5, 6: begin mem_mode = MEM_MODE_OUT; mdr_mem_mode = MDR_MEM_R; end
                7, 8: begin mem_mode = MEM_MODE_IN; mdr_mem_mode = MDR_MEM_W; end
                9: begin
                    mem_mode = MEM_MODE_OUT; mdr_mem_mode = MDR_MEM_R;
                    mar_mode = MAR_BUS_R; bus_in = {6'($urandom), pick_idx()};
                end
                10: if ($urandom_range(0, 3) == 0) begin
                    mar_mode = 2'($urandom); mdr_mode = 2'($urandom);
                    mdr_mem_mode = 2'($urandom); mem_mode = 2'($urandom);
                end
                default: ;
            endcase
            cyc();
        end
        idle(); reset = 1'b0;
        for (int i = 0; i < 20; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
